mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port 256×16 data/instruction RAM, the LED output register and the switch input between two requesters: port 0 is the CPU (fetch and load/store), port 1 is the debug/loader port used to preload programs and inspect results such as mem[25]. It sits between the CPU and the RAM inside the top level. It accepts at most one access per cycle and decodes the 9-bit address into RAM, LED or switch space. It returns read data with a fixed one-cycle latency, tagged to the requester that issued it.

## Interface
- ADDR_W, 9, bus address width
- DATA_W, 16, data width
- RAM_AW, 8, RAM word-address width (addresses 0x000–0x0FF)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req[1:0]  in  2  per-port request, held until granted
- we[1:0]  in  2  per-port write enable (1 = write)
- addr0, addr1  in  ADDR_W  per-port address
- wdata0, wdata1  in  DATA_W  per-port write data
- gnt[1:0]  out  2  one-hot; access accepted this cycle (combinational from req and state)
- rvalid[1:0]  out  2  one-hot; read data valid for that port
- rdata  out  DATA_W  read data, meaningful only while any rvalid bit is set
- err  out  1  one-cycle pulse on access to an unmapped address
- ram_addr  out  RAM_AW; ram_we  out  1; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W  RAM port, synchronous read, 1-cycle latency
- led  out  8  LED register
- sw  in  8  switch input

## Operation
- Address map: 0x000–0x0FF → RAM; 0x100 → LED (write only, low 8 bits); 0x140 → switches (read only, zero-extended); everything else is unmapped.
- Arbitration: at most one gnt bit per cycle. A granted port's request is consumed that cycle. The requester may present a new request on the next cycle.
- Write granted:
  - RAM: ram_we=1 and ram_addr/ram_wdata are driven that cycle.
  - LED: led is updated at the clock edge.
  - No response is returned.
- Read granted: a 1-cycle response is scheduled. Internal state is {pend, owner, src}.
  - The next cycle raises rvalid[owner].
  - rdata is driven from ram_rdata, {8'b0, sw sampled at grant}, or 0, according to src.
- Unmapped access: a write is dropped. A read returns 0 with rvalid. err pulses in the cycle after the grant. A write to 0x140 or a read from 0x100 counts as unmapped.
- Back-to-back: a new grant may occur in the same cycle as the previous read's rvalid, giving full throughput.
- Read-after-write to the same RAM address on consecutive grants returns the new data.

## Timing
- Reset (asynchronous):
  - gnt=0, rvalid=0, rdata=0, err=0, led=0, ram_we=0.
  - Any pending response is discarded.
  - The priority pointer is set to port 0.
- Read latency: grant at cycle N → rvalid and rdata at cycle N+1, for exactly one cycle.
- ram_addr, ram_we and ram_wdata are combinational from the winning port. ram_we is never high without a gnt.
- Reset asserted in the cycle between grant and response: no rvalid is produced after reset releases.
- req asserted while reset_n is low: ignored. The first grant is possible in the first cycle after release.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. After a grant, the other port has priority on the next contention.
  - With contention every cycle, grants alternate 0,1,0,1.
- Not defined:
  - Fixed priority, port 0 always wins.
  - Port 1 is granted only in cycles when req[0]=0.

## Structure
- Package mem_bus_pkg:
  - LED_ADDR=9'h100, SW_ADDR=9'h140.
  - Region enum {REG_RAM, REG_LED, REG_SW, REG_NONE}.
  - Port-id type.
  - Address-decode function.
- Sub-module arb2: the 2-input arbiter, combinational gnt plus the priority pointer register. It contains the ifdef for MEM_ARB_ROUND_ROBIN_EN.
- mem_arbiter holds the decode, the response pipeline register and the LED register.

## Test plan
- Port 1 writes 0x00AB to 0x019, then reads 0x019 → gnt[1] on each access. On the cycle after the read grant, rvalid=2'b10 and rdata=0x00AB.
- Both ports request reads every cycle for 4 cycles:
  - With MEM_ARB_ROUND_ROBIN_EN: grants 01,10,01,10.
  - Without it: gnt=01 in all 4 cycles.
- Port 0 writes 0x0055 to 0x100 → led=0x55 after that edge. sw=0x3C, port 0 reads 0x140 → rdata=0x003C.
- Port 0 reads 0x1FF → rvalid=01 with rdata=0 and err=1 in the following cycle. A write to 0x1FF leaves RAM and led unchanged and pulses err.
- Read granted at cycle N, reset_n pulled low mid-cycle N+0.5 and released → no rvalid; led=0; gnt=0 while reset is low.
- Back-to-back port 0 reads of 0x010 then 0x011, holding 0x1111 and 0x2222 → rvalid=01 on two consecutive cycles with rdata 0x1111 then 0x2222.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for mem_arbiter: address map constants, region
// type, port id type and the address decoder.
package mem_bus_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RAM_AW = 8;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {REG_RAM, REG_LED, REG_SW, REG_NONE} region_t;

    typedef logic port_id_t;
    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // RAM occupies the whole lower half; the upper half has two single words.
    function automatic region_t decode(input logic [ADDR_W-1:0] a);
        region_t r;
        if (!a[ADDR_W-1])      r = REG_RAM;
        else if (a == LED_ADDR) r = REG_LED;
        else if (a == SW_ADDR)  r = REG_SW;
        else                    r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb2.sv
// arb2: two-requester arbiter with a priority pointer register.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise
// port 0 has fixed priority (the pointer is held at port 0).
module arb2
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_id_t   prio;
    port_id_t   prio_nxt;
    logic [1:0] gnt_raw;

    // Single requester wins outright; on contention the pointer decides.
    always_comb begin
        gnt_raw = 2'b00;
        if (req == 2'b11) gnt_raw[prio] = 1'b1;
        else              gnt_raw = req;
        gnt = reset_n ? gnt_raw : 2'b00;
    end

    // Next priority: hand priority to the port that did not just win.
    always_comb begin
        prio_nxt = prio;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (gnt[0])      prio_nxt = PORT1;
        else if (gnt[1]) prio_nxt = PORT0;
`else
        prio_nxt = PORT0;
`endif
    end

    // Priority pointer register, restarts at port 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prio <= PORT0;
        else          prio <= prio_nxt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the 256x16 RAM, LED register and switch input
// between the CPU (port 0) and the debug/loader port (port 1).
// One access per cycle, reads answered one cycle after grant.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed
// priority, implemented inside arb2).
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W,
    parameter int RAM_AW = mem_bus_pkg::RAM_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        led,
    input  logic [7:0]        sw
);

    port_id_t          sel;
    logic              acc;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    region_t           region;
    region_t           eff_region;

    // Response pipeline: {pend, owner, src} plus sampled switches.
    logic              pend;
    port_id_t          owner;
    region_t           src;
    logic [7:0]        sw_q;

    arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    // Steer the winning port onto the shared bus and classify the access.
    // Wrong-direction accesses to LED/switch are treated as unmapped.
    always_comb begin
        acc       = |gnt;
        sel       = gnt[1] ? PORT1 : PORT0;
        we_sel    = we[sel];
        addr_sel  = (sel == PORT1) ? addr1  : addr0;
        wdata_sel = (sel == PORT1) ? wdata1 : wdata0;
        region    = decode(addr_sel);
        eff_region = region;
        if (we_sel && region == REG_SW)   eff_region = REG_NONE;
        if (!we_sel && region == REG_LED) eff_region = REG_NONE;
        ram_addr  = addr_sel[RAM_AW-1:0];
        ram_wdata = wdata_sel;
        ram_we    = acc && we_sel && (eff_region == REG_RAM);
    end

    // Schedule the read response, flag unmapped accesses, update the LEDs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend  <= 1'b0;
            owner <= PORT0;
            src   <= REG_NONE;
            sw_q  <= 8'h00;
            err   <= 1'b0;
            led   <= 8'h00;
        end else begin
            pend  <= acc && !we_sel;
            owner <= sel;
            src   <= eff_region;
            err   <= acc && (eff_region == REG_NONE);
            if (acc && !we_sel && eff_region == REG_SW) sw_q <= sw;
            if (acc && we_sel && eff_region == REG_LED) led <= wdata_sel[7:0];
        end
    end

    // Response data: RAM output is already aligned with the pending cycle.
    always_comb begin
        rvalid = 2'b00;
        rdata  = '0;
        if (pend) begin
            rvalid[owner] = 1'b1;
            case (src)
                REG_RAM: rdata = ram_rdata;
                REG_SW:  rdata = {{(DATA_W-8){1'b0}}, sw_q};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed accesses, responses checked by a
// scoreboard monitor sampling on the falling edge.
module tb_mem_arbiter;

    typedef struct packed {
        logic [1:0]  rvalid;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, we;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        err;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  led, sw;

    logic [15:0] mem [256];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .led(led), .sw(sw)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every response or error pulse must match the next expectation
    always @(negedge clk) begin
        if (reset_n && (rvalid != 2'b00 || err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rvalid=%b rdata=%h err=%b expected none",
                         rvalid, rdata, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rvalid !== e.rvalid || rdata !== e.rdata || err !== e.err) begin
                    errors++;
                    $display("FAIL resp: got rvalid=%b rdata=%h err=%b expected rvalid=%b rdata=%h err=%b",
                             rvalid, rdata, err, e.rvalid, e.rdata, e.err);
                end
            end
        end
    end

    // One access from port p; called at posedge+1, returns at next posedge+1
    task automatic access(input int p, input logic w, input logic [8:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd,
                          input logic exp_err);
        exp_t e;
        req[p] = 1'b1;
        we[p]  = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        #1;
        chk($sformatf("gnt_p%0d_%h", p, a), {30'd0, gnt}, (p == 0) ? 32'd1 : 32'd2);
        if (!w || exp_err) begin
            e.rvalid = w ? 2'b00 : ((p == 0) ? 2'b01 : 2'b10);
            e.rdata  = w ? 16'h0 : exp_rd;
            e.err    = exp_err;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
        we[p]  = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        ram_rdata = 16'h0;
        reset_n = 1'b0;
        req = 2'b11; we = 2'b00;
        addr0 = 9'h010; addr1 = 9'h011; wdata0 = 16'h0; wdata1 = 16'h0;
        sw = 8'h3C;

        // Reset state with requests ignored
        #2;
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_rvalid", {30'd0, rvalid}, 0);
        chk("rst_rdata", {16'd0, rdata}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_led", {24'd0, led}, 0);
        chk("rst_ram_we", {31'd0, ram_we}, 0);
        req = 2'b00;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Port 1 preloads and reads back
        access(1, 1'b1, 9'h010, 16'h1111, 16'h0, 1'b0);
        access(1, 1'b1, 9'h011, 16'h2222, 16'h0, 1'b0);
        access(1, 1'b1, 9'h019, 16'h00AB, 16'h0, 1'b0);
        access(1, 1'b0, 9'h019, 16'h0, 16'h00AB, 1'b0);

        // Contention: both ports read every cycle for 4 cycles
        req = 2'b11; we = 2'b00; addr0 = 9'h010; addr1 = 9'h011;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1;
            chk($sformatf("contention_gnt_%0d", i), {30'd0, gnt}, {30'd0, exp_g});
            e.rvalid = exp_g;
            e.rdata  = (exp_g == 2'b01) ? 16'h1111 : 16'h2222;
            e.err    = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        req = 2'b00;
        @(posedge clk); #1;

        // LED write and switch read (switch sampled at grant)
        access(0, 1'b1, 9'h100, 16'h0055, 16'h0, 1'b0);
        chk("led_write", {24'd0, led}, 32'h55);
        access(0, 1'b0, 9'h140, 16'h0, 16'h003C, 1'b0);
        sw = 8'h99;

        // Unmapped accesses
        access(0, 1'b0, 9'h1FF, 16'h0, 16'h0, 1'b1);
        access(0, 1'b1, 9'h1FF, 16'hFFFF, 16'h0, 1'b1);
        chk("unmapped_wr_led", {24'd0, led}, 32'h55);
        chk("unmapped_wr_ram", {16'd0, mem[8'hFF]}, 0);
        access(0, 1'b1, 9'h140, 16'h0077, 16'h0, 1'b1);
        access(0, 1'b0, 9'h100, 16'h0, 16'h0, 1'b1);
        chk("wr_sw_led", {24'd0, led}, 32'h55);

        // Back-to-back reads and read-after-write
        access(0, 1'b0, 9'h010, 16'h0, 16'h1111, 1'b0);
        access(0, 1'b0, 9'h011, 16'h0, 16'h2222, 1'b0);
        access(0, 1'b1, 9'h020, 16'hBEEF, 16'h0, 1'b0);
        access(0, 1'b0, 9'h020, 16'h0, 16'hBEEF, 1'b0);
        @(posedge clk); #1;

        // Reset between grant and response drops the response
        req[0] = 1'b1; we[0] = 1'b0; addr0 = 9'h010;
        #1;
        chk("pre_rst_gnt", {30'd0, gnt}, 1);
        #1; reset_n = 1'b0;
        #1;
        chk("mid_rst_gnt", {30'd0, gnt}, 0);
        chk("mid_rst_led", {24'd0, led}, 0);
        chk("mid_rst_rvalid", {30'd0, rvalid}, 0);
        @(posedge clk); #1;
        chk("hold_rst_gnt", {30'd0, gnt}, 0);
        req = 2'b00;
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // First access after reset release
        access(0, 1'b0, 9'h010, 16'h0, 16'h1111, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
